// File: rtl/spi_slave_responder_pkg.sv
// Shared types and constants for the SPI responder and its input synchronizer.
// Mode 0 link: SCLK idles low, data sampled on rise, changed on fall, LSB first.
package spi_slave_responder_pkg;

    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefSyncStages = 2;
    localparam logic        SclkIdle      = 1'b0;

    typedef enum logic [1:0] {
        StWaitIdle = 2'd0,
        StIdle     = 2'd1,
        StActive   = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_responder_input_sync.sv
// Multi-flop synchronizer for SCLK, CS_N and MOSI, plus one-cycle SCLK rise/fall
// pulses derived from the last two synchronized SCLK samples.
module spi_slave_responder_input_sync
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sclk_o,
    output logic cs_n_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] cs_n_q, cs_n_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk_i};
        cs_n_d      = {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
        mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi_i};
        sclk_prev_d = sclk_q[SYNC_STAGES-1];
    end

    // CS_N clears to 0 so a frame already in progress at reset is never taken as idle.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sclk_q      <= {SYNC_STAGES{SclkIdle}};
            cs_n_q      <= '0;
            mosi_q      <= '0;
            sclk_prev_q <= SclkIdle;
        end else begin
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_o      = sclk_q[SYNC_STAGES-1];
    assign cs_n_o      = cs_n_q[SYNC_STAGES-1];
    assign mosi_o      = mosi_q[SYNC_STAGES-1];
    assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode-0 SPI responder: full-duplex LSB-first words, one-deep TX holding register,
// held RX word with full/overrun flags, all driven from oversampled SPI pins.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  SCLK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_WRITE,
    output logic                  TX_FULL,
    output logic                  TX_UNDERRUN,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_READ,
    output logic                  RX_FULL,
    output logic                  RX_OVERRUN,
    output logic                  BUSY
);

    localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    logic sclk_s, cs_n_s, mosi_s, sclk_rise, sclk_fall;

    spi_slave_responder_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (CLK),
        .clr_i       (CLR),
        .sclk_i      (SCLK),
        .cs_n_i      (CS_N),
        .mosi_i      (MOSI),
        .sclk_o      (sclk_s),
        .cs_n_o      (cs_n_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall)
    );

    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  tx_full_q, tx_full_d;
    logic                  tx_underrun_q, tx_underrun_d;
    logic                  rx_full_q, rx_full_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  reload;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_hold_d     = tx_hold_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        tx_full_d     = tx_full_q;
        tx_underrun_d = tx_underrun_q;
        rx_full_d     = rx_full_q;
        rx_overrun_d  = rx_overrun_q;
        reload        = 1'b0;

        if (RX_READ && rx_full_q) begin
            rx_full_d    = 1'b0;
            rx_overrun_d = 1'b0;
        end

        case (state_q)
            StWaitIdle: begin
                if (cs_n_s) state_d = StIdle;
            end
            StIdle: begin
                if (!cs_n_s) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            StActive: begin
                if (cs_n_s) begin
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    tx_shift_d = '0;
                    rx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        rx_data_d = rx_shift_d;
                        rx_full_d = 1'b1;
                        if (rx_full_q && !RX_READ) rx_overrun_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) reload = 1'b1;
                    else                 tx_shift_d = tx_shift_q >> 1;
                end
            end
            default: state_d = StWaitIdle;
        endcase

        if (reload) begin
            tx_shift_d = tx_full_q ? tx_hold_q : '0;
            if (tx_full_q) tx_full_d     = 1'b0;
            else           tx_underrun_d = 1'b1;
        end

        // A reload that empties the holding register lets a same-cycle write land.
        if (TX_WRITE && (!tx_full_q || reload)) begin
            tx_hold_d = TX_DATA;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q       <= StWaitIdle;
            bit_cnt_q     <= '0;
            tx_hold_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            tx_full_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_full_q     <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_hold_q     <= tx_hold_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            tx_full_q     <= tx_full_d;
            tx_underrun_q <= tx_underrun_d;
            rx_full_q     <= rx_full_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign BUSY        = (state_q == StActive);
    assign MISO        = (state_q == StActive) & tx_shift_q[0];
    assign TX_FULL     = tx_full_q;
    assign TX_UNDERRUN = tx_underrun_q;
    assign RX_DATA     = rx_data_q;
    assign RX_FULL     = rx_full_q;
    assign RX_OVERRUN  = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed plus randomized bench for spi_slave_responder; a word-level model of the
// holding register and RX flags supplies every expected value.
module tb_spi_slave_responder;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          clr, sclk, cs_n, mosi, miso;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_write, tx_full, tx_underrun, rx_read, rx_full, rx_overrun, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_slave_responder #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK         (clk),
        .CLR         (clr),
        .SCLK        (sclk),
        .CS_N        (cs_n),
        .MOSI        (mosi),
        .MISO        (miso),
        .TX_DATA     (tx_data),
        .TX_WRITE    (tx_write),
        .TX_FULL     (tx_full),
        .TX_UNDERRUN (tx_underrun),
        .RX_DATA     (rx_data),
        .RX_READ     (rx_read),
        .RX_FULL     (rx_full),
        .RX_OVERRUN  (rx_overrun),
        .BUSY        (busy)
    );

    // Word-level reference state
    logic [DW-1:0] m_hold, m_rx_data;
    bit            m_full, m_underrun, m_rx_full, m_overrun;

    task automatic m_reset();
        m_hold = '0; m_rx_data = '0;
        m_full = 0; m_underrun = 0; m_rx_full = 0; m_overrun = 0;
    endtask

    task automatic m_write(input logic [DW-1:0] v);
        if (!m_full) begin
            m_hold = v;
            m_full = 1;
        end
    endtask

    task automatic m_consume(output logic [DW-1:0] w);
        if (m_full) begin
            w = m_hold;
            m_full = 0;
        end else begin
            w = '0;
            m_underrun = 1;
        end
    endtask

    task automatic m_rx(input logic [DW-1:0] w, input bit read_same);
        if (read_same) m_overrun = 0;
        else if (m_rx_full) m_overrun = 1;
        m_rx_data = w;
        m_rx_full = 1;
    endtask

    task automatic m_read();
        if (m_rx_full) begin
            m_rx_full = 0;
            m_overrun = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".tx_full"},  32'(tx_full),     32'(m_full));
        check({tag, ".underrun"}, 32'(tx_underrun), 32'(m_underrun));
        check({tag, ".rx_full"},  32'(rx_full),     32'(m_rx_full));
        check({tag, ".overrun"},  32'(rx_overrun),  32'(m_overrun));
        check({tag, ".rx_data"},  32'(rx_data),     32'(m_rx_data));
    endtask

    task automatic tx_wr(input logic [DW-1:0] v);
        tx_data = v;
        tx_write = 1'b1;
        @(negedge clk);
        tx_write = 1'b0;
    endtask

    task automatic rx_rd();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (SYNC + 2) @(negedge clk);
    endtask

    // One master word; on the last word of a frame SCLK falls together with CS_N rising.
    task automatic spi_word(input logic [DW-1:0] tx, input bit last, input bit rd_on_done,
                            output logic [DW-1:0] rx);
        for (int i = 0; i < DW; i++) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                rx_read = (rd_on_done && i == DW - 1 && j == SYNC);
            end
            sclk = 1'b0;
            if (last && i == DW - 1) cs_n = 1'b1;
        end
    endtask

    task automatic spi_edges(input int n);
        for (int i = 0; i < n; i++) begin
            if (!sclk) mosi = 1'($urandom_range(1, 0));
            repeat (HALF) @(negedge clk);
            sclk = ~sclk;
        end
    endtask

    initial begin
        logic [DW-1:0] e1, e2, g1, g2, r1, r2, w;
        int            nw;

        clr = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_write = 1'b0; rx_read = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.miso", 32'(miso), 32'd0);
        check_flags("reset");
        clr = 1'b0;
        settle();

        // Single word: A5 out, 3C in
        tx_wr(8'hA5); m_write(8'hA5);
        check("t1.tx_full_pre", 32'(tx_full), 32'd1);
        frame_begin();
        check("t1.busy", 32'(busy), 32'd1);
        m_consume(e1);
        spi_word(8'h3C, 1, 0, g1); m_rx(8'h3C, 0);
        settle();
        check("t1.miso", 32'(g1), 32'(e1));
        check("t1.busy_after", 32'(busy), 32'd0);
        check_flags("t1");
        rx_rd(); m_read();
        check_flags("t1.read");

        // Back-to-back words with second write during word 1
        tx_wr(8'h01); m_write(8'h01);
        frame_begin();
        m_consume(e1);
        tx_wr(8'h80); m_write(8'h80);
        r1 = 8'($urandom_range(255, 0)); r2 = 8'($urandom_range(255, 0));
        spi_word(r1, 0, 0, g1); m_rx(r1, 0);
        check("t2.miso1", 32'(g1), 32'(e1));
        check("t2.rx_full1", 32'(rx_full), 32'd1);
        rx_rd(); m_read();
        m_consume(e2);
        spi_word(r2, 1, 0, g2); m_rx(r2, 0);
        settle();
        check("t2.miso2", 32'(g2), 32'(e2));
        check_flags("t2");
        rx_rd(); m_read();

        // Empty holding register, two unread words
        frame_begin();
        r1 = 8'($urandom_range(255, 0)); r2 = 8'($urandom_range(255, 0));
        m_consume(e1);
        spi_word(r1, 0, 0, g1); m_rx(r1, 0);
        m_consume(e2);
        spi_word(r2, 1, 0, g2); m_rx(r2, 0);
        settle();
        check("t3.miso1", 32'(g1), 32'(e1));
        check("t3.miso2", 32'(g2), 32'(e2));
        check_flags("t3");
        rx_rd(); m_read();
        check_flags("t3.read");

        // Frame aborted after 5 SCLK edges, then a clean FF word
        frame_begin(); m_consume(e1);
        spi_edges(5);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        settle();
        check("t4.busy", 32'(busy), 32'd0);
        check_flags("t4.abort");
        frame_begin(); m_consume(e1);
        spi_word(8'hFF, 1, 0, g1); m_rx(8'hFF, 0);
        settle();
        check("t4.miso", 32'(g1), 32'(e1));
        check_flags("t4.ff");

        // CLR mid-frame with CS_N held low
        w = 8'($urandom_range(255, 0));
        tx_wr(w); m_write(w);
        frame_begin(); m_consume(e1);
        spi_edges(4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_reset();
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.miso", 32'(miso), 32'd0);
        check_flags("t5.clr");
        spi_word(8'($urandom_range(255, 0)), 0, 0, g1);
        check("t5.ignored_miso", 32'(g1), 32'd0);
        check("t5.ignored_busy", 32'(busy), 32'd0);
        check_flags("t5.ignored");
        cs_n = 1'b1;
        settle();

        // Same-cycle RX_READ on completion, TX_WRITE on reload
        tx_wr(8'h5A); m_write(8'h5A);
        frame_begin(); m_consume(e1);
        tx_wr(8'hC3); m_write(8'hC3);
        r1 = 8'($urandom_range(255, 0)); r2 = 8'($urandom_range(255, 0));
        spi_word(r1, 0, 0, g1); m_rx(r1, 0);
        repeat (SYNC) @(negedge clk);
        tx_wr(8'h96);
        m_consume(e2); m_write(8'h96);
        spi_word(r2, 1, 1, g2); m_rx(r2, 1);
        settle();
        check("t6.miso1", 32'(g1), 32'(e1));
        check("t6.miso2", 32'(g2), 32'(e2));
        check_flags("t6");
        rx_rd(); m_read();
        frame_begin(); m_consume(e1);
        spi_word(8'h00, 1, 0, g1); m_rx(8'h00, 0);
        settle();
        check("t6.held_word", 32'(g1), 32'(e1));
        check_flags("t6.after");

        // Random frames
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                w = 8'($urandom_range(255, 0));
                tx_wr(w); m_write(w);
            end
            nw = int'($urandom_range(3, 1));
            frame_begin();
            for (int n = 0; n < nw; n++) begin
                r1 = 8'($urandom_range(255, 0));
                m_consume(e1);
                spi_word(r1, (n == nw - 1), 0, g1); m_rx(r1, 0);
                check($sformatf("rnd%0d.w%0d.miso", k, n), 32'(g1), 32'(e1));
                if ($urandom_range(1, 0) == 1) begin
                    rx_rd(); m_read();
                end
            end
            settle();
            check_flags($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
